// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg
// Shared definitions for the multiply/divide unit.
//   - R-format function codes handled by the unit (FN_MFHI .. FN_DIVU)
//   - FSM state type and encodings (ST_IDLE, ST_MUL, ST_DIV, ST_FIX)
//   - decode helpers is_muldiv / is_mul / is_div
package alu_muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_FIX  = 2'd3;

  // Any code this unit responds to (moves, reads, multiply, divide).
  function automatic logic is_muldiv(input logic [5:0] func);
    return (func == FN_MFHI) || (func == FN_MTHI) || (func == FN_MFLO) ||
           (func == FN_MTLO) || (func == FN_MULT) || (func == FN_MULTU) ||
           (func == FN_DIV)  || (func == FN_DIVU);
  endfunction

  function automatic logic is_mul(input logic [5:0] func);
    return (func == FN_MULT) || (func == FN_MULTU);
  endfunction

  function automatic logic is_div(input logic [5:0] func);
    return (func == FN_DIV) || (func == FN_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if
// Pipeline-side bundle of the multiply/divide unit.
//   start, func, rs, rt          : request from the execute stage (master drives)
//   rd_data, hi, lo              : MF* read data and architectural HI/LO
//   busy, done, stall            : status back to the pipeline (slave drives)
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       func;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, func, rs, rt,
    input  rd_data, hi, lo, busy, done, stall
  );

  modport slave (
    input  start, func, rs, rt,
    output rd_data, hi, lo, busy, done, stall
  );
endinterface

// File: rtl/alu_muldiv_iter_core.sv
// muldiv_iter_core
// Shared one-bit-per-cycle datapath for unsigned shift-add multiply and
// restoring divide. Operands are magnitudes; sign handling lives in the top.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            capture operands and clear accumulator/step counter
//   div_mode        at load: 1 = divide, 0 = multiply
//   a, b            multiplier / dividend, multiplicand / divisor
//   step            perform one iteration
//   hi, lo          multiply: product {hi,lo}; divide: remainder hi, quotient lo
//   last            the current step is the final (WIDTH-th) one
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] hi_reg, lo_reg, b_reg;
  logic [CW-1:0]    cnt_reg;
  logic             div_reg;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] hi_next, lo_next;

  always_comb begin
    // Multiply: conditionally add multiplicand, shift {carry,hi,lo} right.
    sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    // Divide: shift the next dividend bit into the partial remainder.
    shifted = {hi_reg, lo_reg[WIDTH-1]};
    fits    = (shifted >= {1'b0, b_reg});
    // When it fits, the true difference is below the divisor so W bits suffice.
    diff    = shifted[WIDTH-1:0] - b_reg;
    if (div_reg) begin
      hi_next = fits ? diff : shifted[WIDTH-1:0];
      lo_next = {lo_reg[WIDTH-2:0], fits};
    end else begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg  <= '0;
      lo_reg  <= '0;
      b_reg   <= '0;
      cnt_reg <= '0;
      div_reg <= 1'b0;
    end else if (load) begin
      hi_reg  <= '0;
      lo_reg  <= a;
      b_reg   <= b;
      cnt_reg <= '0;
      div_reg <= div_mode;
    end else if (step) begin
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign hi   = hi_reg;
  assign lo   = lo_reg;
  assign last = (cnt_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Handles MULT/MULTU/DIV/DIVU (iterative, WIDTH+1 edges to result),
// MTHI/MTLO (write next edge) and MFHI/MFLO (combinational read).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any operation)
//   bus    alu_muldiv_if.slave: start/func/rs/rt in; rd_data/hi/lo/busy/done/stall out
// Option: ALU_MULDIV_FAST_MUL_EN -> multiply in one cycle (IDLE -> FIX -> IDLE).
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  alu_muldiv_if.slave bus
);
  localparam int W2 = 2 * WIDTH;

  state_t           state_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg, rs_orig_reg;
  logic             done_reg, neg_res_reg, neg_rem_reg, div_zero_reg, is_div_reg;

  logic             busy, accept_mul, accept_div, is_signed, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic             core_last, core_step;
  logic [W2-1:0]    prod_raw, prod_fix;
  logic [WIDTH-1:0] fix_hi, fix_lo, rd_data;

  assign busy       = (state_reg != ST_IDLE);
  assign accept_mul = bus.start && is_mul(bus.func) && !busy;
  assign accept_div = bus.start && is_div(bus.func) && !busy;
  assign is_signed  = (bus.func == FN_MULT) || (bus.func == FN_DIV);
  assign neg_a      = is_signed && bus.rs[WIDTH-1];
  assign neg_b      = is_signed && bus.rt[WIDTH-1];
  assign mag_a      = neg_a ? (~bus.rs + WIDTH'(1)) : bus.rs;
  assign mag_b      = neg_b ? (~bus.rt + WIDTH'(1)) : bus.rt;
  assign core_step  = (state_reg == ST_MUL) || (state_reg == ST_DIV);

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_mul || accept_div),
    .div_mode (accept_div),
    .a        (mag_a),
    .b        (mag_b),
    .step     (core_step),
    .hi       (core_hi),
    .lo       (core_lo),
    .last     (core_last)
  );

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic [WIDTH-1:0] fast_a_reg, fast_b_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fast_a_reg <= '0;
      fast_b_reg <= '0;
    end else if (accept_mul) begin
      fast_a_reg <= mag_a;
      fast_b_reg <= mag_b;
    end
  end

  // Magnitude product; sign applied below exactly as for the iterative path.
  assign prod_raw = {{WIDTH{1'b0}}, fast_a_reg} * {{WIDTH{1'b0}}, fast_b_reg};
`else
  assign prod_raw = {core_hi, core_lo};
`endif

  // Sign correction and special cases, consumed in ST_FIX.
  always_comb begin
    prod_fix = neg_res_reg ? (~prod_raw + W2'(1)) : prod_raw;
    fix_hi   = prod_fix[W2-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      if (div_zero_reg) begin
        fix_hi = rs_orig_reg;
        fix_lo = '1;
      end else begin
        // MIN / -1 falls out naturally: |MIN| = 2^(W-1), negated back to MIN.
        fix_lo = neg_res_reg ? (~core_lo + WIDTH'(1)) : core_lo;
        fix_hi = neg_rem_reg ? (~core_hi + WIDTH'(1)) : core_hi;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      hi_reg       <= '0;
      lo_reg       <= '0;
      rs_orig_reg  <= '0;
      done_reg     <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      is_div_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept_mul || accept_div) begin
            rs_orig_reg  <= bus.rs;
            neg_res_reg  <= neg_a ^ neg_b;
            neg_rem_reg  <= neg_a;
            div_zero_reg <= (bus.rt == '0);
            is_div_reg   <= accept_div;
            if (accept_div) begin
              state_reg <= ST_DIV;
            end else begin
`ifdef ALU_MULDIV_FAST_MUL_EN
              state_reg <= ST_FIX;
`else
              state_reg <= ST_MUL;
`endif
            end
          end else if (bus.start && (bus.func == FN_MTHI)) begin
            hi_reg <= bus.rs;
          end else if (bus.start && (bus.func == FN_MTLO)) begin
            lo_reg <= bus.rs;
          end
        end
        ST_MUL, ST_DIV: begin
          if (core_last) state_reg <= ST_FIX;
        end
        ST_FIX: begin
          hi_reg    <= fix_hi;
          lo_reg    <= fix_lo;
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (bus.func == FN_MFHI)      rd_data = hi_reg;
    else if (bus.func == FN_MFLO) rd_data = lo_reg;
  end

  assign bus.rd_data = rd_data;
  assign bus.hi      = hi_reg;
  assign bus.lo      = lo_reg;
  assign bus.busy    = busy;
  assign bus.done    = done_reg;
  assign bus.stall   = bus.start && is_muldiv(bus.func) && busy;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv
// Directed plus randomized checks of alu_muldiv (WIDTH = 32) against a
// plain-arithmetic reference model. Honors ALU_MULDIV_FAST_MUL_EN for the
// expected multiply latency.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_hi, exp_lo;

  alu_muldiv_if #(.WIDTH(32)) bus ();

  alu_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: results straight from the arithmetic rules.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint      la, lb, p;
    int          sa, sb;
    logic [63:0] up;
    eh = '0;
    el = '0;
    case (f)
      FN_MULT: begin
        la = longint'($signed(a));
        lb = longint'($signed(b));
        p  = la * lb;
        {eh, el} = p;
      end
      FN_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {eh, el} = up;
      end
      FN_DIV: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          el = a; eh = 32'd0;
        end else begin
          sa = a; sb = b;
          el = sa / sb;
          eh = sa % sb;
        end
      end
      FN_DIVU: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Issue one mul/div, wait for done, check latency and HI/LO, read back via MF*.
  // Returns in the done cycle so the next call issues back-to-back.
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eh, el;
    int          n;
    bit          seen;
    int          lat;
    model(f, a, b, eh, el);
    lat = is_mul(f) ? MUL_LAT : DIV_LAT;
    bus.start = 1'b1; bus.func = f; bus.rs = a; bus.rt = b;
    chk({tag, " stall_at_accept"}, 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.func = 6'd0;
    chk({tag, " busy_after_accept"}, 64'(bus.busy), 64'd1);
    chk({tag, " done_pulse_low"}, 64'(bus.done), 64'd0);
    n = 1; seen = 0;
    while (!seen && n <= 100) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1; else n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, " lo"}, 64'(bus.lo), 64'(el));
    chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    bus.func = FN_MFHI; #1;
    chk({tag, " mfhi"}, 64'(bus.rd_data), 64'(eh));
    bus.func = FN_MFLO; #1;
    chk({tag, " mflo"}, 64'(bus.rd_data), 64'(el));
    bus.func = 6'd0;
    exp_hi = eh; exp_lo = el;
    $display("op %s func=%b rs=%h rt=%h hi=%h lo=%h latency=%0d", tag, f, a, b, bus.hi, bus.lo, n);
  endtask

  initial begin : main
    logic [5:0]  codes [4];
    logic [5:0]  f;
    logic [31:0] a, b;
    int          n;
    bit          seen;

    codes[0] = FN_MULT; codes[1] = FN_MULTU; codes[2] = FN_DIV; codes[3] = FN_DIVU;
    bus.start = 1'b0; bus.func = 6'd0; bus.rs = '0; bus.rt = '0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset stall", 64'(bus.stall), 64'd0);
    rst_n = 1'b1;
    $display("step reset hi=%h lo=%h busy=%b done=%b", bus.hi, bus.lo, bus.busy, bus.done);
    @(posedge clk); #1;

    // Directed arithmetic cases (back-to-back issue after each done)
    do_op(FN_MULT,  32'hFFFF_FFFD, 32'd7,         "mult_neg3x7");
    chk("mult_neg3x7 hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("mult_neg3x7 lo_const", 64'(bus.lo), 64'hFFFF_FFEB);
    do_op(FN_MULTU, 32'hFFFF_FFFF, 32'd2,         "multu_max_x2");
    chk("multu hi_const", 64'(bus.hi), 64'h1);
    chk("multu lo_const", 64'(bus.lo), 64'hFFFF_FFFE);
    do_op(FN_DIV,   32'hFFFF_FFF9, 32'd2,         "div_neg7_2");
    chk("div_neg7_2 lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
    chk("div_neg7_2 hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
    do_op(FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    chk("div_min_m1 lo_const", 64'(bus.lo), 64'h8000_0000);
    chk("div_min_m1 hi_const", 64'(bus.hi), 64'h0);
    do_op(FN_DIVU,  32'h64,        32'd0,         "divu_by0");
    chk("divu_by0 hi_const", 64'(bus.hi), 64'h64);
    chk("divu_by0 lo_const", 64'(bus.lo), 64'hFFFF_FFFF);
    do_op(FN_DIV,   32'hFFFF_FFFB, 32'd0,         "div_neg_by0");
    do_op(FN_DIV,   32'd7,         32'hFFFF_FFFE, "div_7_neg2");

    // Unrecognised code: no state change
    bus.start = 1'b1; bus.func = 6'b100000; bus.rs = 32'hDEAD_BEEF; bus.rt = 32'd1;
    #1;
    chk("badcode stall", 64'(bus.stall), 64'd0);
    chk("badcode rd_data", 64'(bus.rd_data), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("badcode busy", 64'(bus.busy), 64'd0);
    chk("badcode hi", 64'(bus.hi), 64'(exp_hi));
    chk("badcode lo", 64'(bus.lo), 64'(exp_lo));
    $display("step badcode hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);

    // MTHI / MTLO visible one cycle after accept, no done pulse
    bus.start = 1'b1; bus.func = FN_MTHI; bus.rs = 32'hCAFE_0001;
    @(posedge clk); #1;
    bus.func = FN_MTLO; bus.rs = 32'h0BAD_F00D;
    chk("mthi hi", 64'(bus.hi), 64'hCAFE_0001);
    chk("mthi done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.func = FN_MFLO;
    #1;
    chk("mtlo lo", 64'(bus.lo), 64'h0BAD_F00D);
    chk("mtlo mflo", 64'(bus.rd_data), 64'h0BAD_F00D);
    chk("mtlo busy", 64'(bus.busy), 64'd0);
    $display("step mthi/mtlo hi=%h lo=%h", bus.hi, bus.lo);

    // MFLO during MULT 6x7: stall until the done cycle, ignored MULT while busy
    bus.start = 1'b1; bus.func = FN_MULT; bus.rs = 32'd6; bus.rt = 32'd7;
    @(posedge clk); #1;
    bus.rs = 32'd9; bus.rt = 32'd9;
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      if (bus.done) begin
        seen = 1;
      end else begin
        chk("stall while busy", 64'(bus.stall), 64'd1);
        if (n == 5) bus.func = FN_MFLO;
        @(posedge clk); #1;
        n++;
      end
    end
    bus.func = FN_MFLO; #1;
    chk("stall latency", 64'(n), 64'(MUL_LAT));
    chk("stall released", 64'(bus.stall), 64'd0);
    chk("stall mflo value", 64'(bus.rd_data), 64'h2A);
    chk("stall hi", 64'(bus.hi), 64'd0);
    bus.start = 1'b0; bus.func = 6'd0;
    $display("step mflo_stall lo=%h cycles=%0d", bus.lo, n);

    // MTHI then reset in the middle of a DIV
    @(posedge clk); #1;
    bus.start = 1'b1; bus.func = FN_MTHI; bus.rs = 32'h1234;
    @(posedge clk); #1;
    chk("mthi_1234 hi", 64'(bus.hi), 64'h1234);
    bus.func = FN_DIV; bus.rs = 32'd1000; bus.rt = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.func = 6'd0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset hi", 64'(bus.hi), 64'd0);
    chk("midreset lo", 64'(bus.lo), 64'd0);
    chk("midreset busy", 64'(bus.busy), 64'd0);
    chk("midreset done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midreset done_after_edge", 64'(bus.done), 64'd0);
    $display("step midreset hi=%h lo=%h busy=%b done=%b", bus.hi, bus.lo, bus.busy, bus.done);
    @(posedge clk); #1;
    do_op(FN_DIVU, 32'd10, 32'd3, "divu_10_3");
    chk("divu_10_3 lo_const", 64'(bus.lo), 64'd3);
    chk("divu_10_3 hi_const", 64'(bus.hi), 64'd1);

    // Randomized operations against the reference model
    for (int i = 0; i < 16; i++) begin
      f = codes[$urandom_range(3, 0)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(5, 0))
        0: b = 32'd0;
        1: b = 32'(32'($urandom_range(15, 1)));
        2: a = 32'h8000_0000;
        default: ;
      endcase
      do_op(f, a, b, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It is the execute-stage companion to the ALU control decoder. It accepts R-format MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO function codes and runs iterative shift-add multiplication and restoring division, one bit per cycle. It exposes a stall to the pipeline while a result is pending.

## Interface
Parameters:
- WIDTH, 32: operand and HI/LO width in bits (≥ 4).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request valid for one cycle; ignored unless func is a recognised muldiv code.
- func  in  6  R-format function field.
- rs  in  WIDTH  first operand (multiplicand / dividend / MT source).
- rt  in  WIDTH  second operand (multiplier / divisor).
- rd_data  out  WIDTH  HI for MFHI and LO for MFLO, combinational; 0 otherwise.
- hi  out  WIDTH  current HI register.
- lo  out  WIDTH  current LO register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO take a mul/div result.
- stall  out  1  start && (MF*/MT*/mul/div code) && busy.

## Operation
- Function codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. Other codes are ignored; no state change.
- States: IDLE, MUL, DIV, FIX.
  - IDLE: on start with a mul code, go to MUL; with a div code, go to DIV.
  - MUL/DIV: iterate WIDTH steps, then go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse done, return to IDLE.
- Signed ops (MULT, DIV) take operand magnitudes at accept and store the result signs.
- Multiply: 2·WIDTH-bit product. HI holds the upper WIDTH bits and LO the lower WIDTH bits. Signed results are two's-complement negated in FIX when the signs differ.
- Divide: the quotient goes to LO and the remainder to HI.
  - Signed: the quotient truncates toward zero; the remainder takes the sign of the dividend.
  - MIN / −1: LO = MIN, HI = 0.
  - Divisor 0 (signed or unsigned): HI = rs, LO = all ones. Full latency; done still pulses.
- MTHI/MTLO: accepted only in IDLE; write HI/LO at the next edge; no done pulse.
- MFHI/MFLO: rd_data reflects the register combinationally. While busy, stall is asserted and the read value is not valid.
- Start of any muldiv code while busy is ignored (stall is asserted); the in-flight operation continues unaffected.
- Reset: hi = 0, lo = 0, busy = 0, done = 0, state = IDLE.
- Reset mid-operation: aborts immediately. No HI/LO write and no done pulse.

## Timing
- Accept edge E0: operands are latched and busy rises after E0.
- Iteration edges E1..E_WIDTH, then FIX at E_WIDTH+1. HI/LO are updated at E_WIDTH+1.
- done is high and busy low in the cycle after E_WIDTH+1. Latency is WIDTH+1 edges from accept to visible result (33 for WIDTH = 32).
- A new start is accepted in the same cycle done is high (back-to-back). An MF* in that cycle reads the new value.
- MT* write is visible one cycle after accept.
- stall is combinational from start, func and busy. It has no registered delay.

## Configuration
- ALU_MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU use a single-cycle WIDTH×WIDTH product (signed/unsigned as per code), registered at E1.
  - done is high in the cycle after E1 (latency 1); state goes IDLE → FIX → IDLE.
  - Divide is unchanged.
- Undefined: iterative multiply as above (latency WIDTH+1).

## Structure
- Package alu_muldiv_pkg holds:
  - the func code localparams (FN_MFHI … FN_DIVU);
  - the state enum (ST_IDLE, ST_MUL, ST_DIV, ST_FIX);
  - the helper function is_muldiv(func).
- One sub-module, muldiv_iter_core, holds the shared accumulator/shift datapath and step counter for both multiply and divide. The top holds the FSM, sign handling, HI/LO and the pipeline interface.

## Test plan
- MULT rs = 0xFFFFFFFD (−3), rt = 7 → done after 33 edges; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- MULTU rs = 0xFFFFFFFF, rt = 2 → HI = 0x00000001, LO = 0xFFFFFFFE. With ALU_MULDIV_FAST_MUL_EN, the same result arrives with done one cycle after accept.
- DIV rs = 0xFFFFFFF9 (−7), rt = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU rs = 0x64, rt = 0 → HI = 0x00000064, LO = 0xFFFFFFFF; done pulses normally.
- MFLO issued 5 cycles into MULT 6 × 7 → stall = 1 until the done cycle. The MFLO retried in the done cycle reads rd_data = 0x2A. A MULT issued while busy is ignored.
- MTHI 0x1234 followed by reset asserted at cycle 10 of a DIV → hi = lo = 0, busy = done = 0 immediately. After release, a DIVU 10/3 gives LO = 3, HI = 1.
